// File: rtl/matrix_exec_unit.sv
// Execute-stage matrix coprocessor: element loads into A/B and C = A*B on one sequential MAC.
// Optional build macro MATMUL_SATURATE_EN clamps each C element instead of wrapping it.
module matrix_exec_unit #(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              load_a_en,
    input  logic              load_b_en,
    input  logic              matmul_en,
    input  logic              inv_en,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              stall,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              illegal_op
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;
    typedef logic signed [DATA_W-1:0] elem_t;
    typedef elem_t mat_t [N][N];

    state_e                   state_q, state_d;
    mat_t                     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [CNT_W-1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     result_valid_q, result_valid_d;
    logic [DATA_W-1:0]        result_data_q, result_data_d;
    logic                     illegal_q, illegal_d;

    logic [IDX_W-1:0]         rs_idx;
    logic                     rs_idx_ok;
    logic                     multi_en;
    logic                     rs2_unused;
    elem_t                    a_el, b_el, mac_res;
    logic signed [2*DATA_W-1:0] prod_full;
    logic signed [ACC_W-1:0]  mac_sum;

    assign rs_idx     = rs2_data[IDX_W-1:0];
    assign rs2_unused = ^rs2_data[DATA_W-1:IDX_W];
    assign rs_idx_ok  = int'(rs_idx) < N * N;
    assign multi_en   = $countones({matmul_en, load_a_en, load_b_en, inv_en}) > 1;

    // The instruction in ID/EX is held while the MAC runs; DONE releases it.
    assign stall = ~reset & ((state_q == S_IDLE && issue_valid && matmul_en) || state_q == S_MAC);

    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign illegal_op   = illegal_q;

    always_comb begin
        a_el      = a_q[i_q][k_q];
        b_el      = b_q[k_q][j_q];
        prod_full = $signed({{DATA_W{a_el[DATA_W-1]}}, a_el})
                  * $signed({{DATA_W{b_el[DATA_W-1]}}, b_el});
        mac_sum   = acc_q + {{CNT_W{prod_full[2*DATA_W-1]}}, prod_full};
`ifdef MATMUL_SATURATE_EN
        if (mac_sum[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){mac_sum[ACC_W-1]}})
            mac_res = mac_sum[DATA_W-1:0];
        else if (mac_sum[ACC_W-1])
            mac_res = {1'b1, {(DATA_W-1){1'b0}}};
        else
            mac_res = {1'b0, {(DATA_W-1){1'b1}}};
`else
        mac_res = mac_sum[DATA_W-1:0];
`endif
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        i_d            = i_q;
        j_d            = j_q;
        k_d            = k_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        result_valid_d = 1'b0;
        result_data_d  = result_data_q;
        illegal_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    illegal_d = multi_en;
                    if (matmul_en) begin
                        idx_d   = rs_idx;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else if (load_a_en || load_b_en) begin
                        result_valid_d = 1'b1;
                        if (rs_idx_ok) begin
                            result_data_d = rs1_data;
                            for (int r = 0; r < N; r++)
                                for (int c = 0; c < N; c++)
                                    if (IDX_W'(r * N + c) == rs_idx) begin
                                        if (load_a_en) a_d[r][c] = rs1_data;
                                        else           b_d[r][c] = rs1_data;
                                    end
                        end else begin
                            result_data_d = '0;
                            illegal_d     = 1'b1;
                        end
                    end else if (inv_en) begin
                        result_valid_d = 1'b1;
                        result_data_d  = '0;
                        illegal_d      = 1'b1;
                    end
                end
            end

            S_MAC: begin
                if (k_q == LAST) begin
                    // NOTE: blocking writes here let the final element be read back from c_d in the same cycle.
                    c_d[i_q][j_q] = mac_res;
                    acc_d         = '0;
                    k_d           = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d            = '0;
                            state_d        = S_DONE;
                            result_valid_d = 1'b1;
                            result_data_d  = '0;
                            illegal_d      = int'(idx_q) >= N * N;
                            for (int r = 0; r < N; r++)
                                for (int c = 0; c < N; c++)
                                    if (IDX_W'(r * N + c) == idx_q)
                                        result_data_d = c_d[r][c];
                        end else begin
                            i_d = i_q + CNT_W'(1);
                        end
                    end else begin
                        j_d = j_q + CNT_W'(1);
                    end
                end else begin
                    acc_d = mac_sum;
                    k_d   = k_q + CNT_W'(1);
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            // NOTE: the matrix arrays must read as zero after reset, so they are cleared like ordinary flops.
            a_q            <= '{default: '0};
            b_q            <= '{default: '0};
            c_q            <= '{default: '0};
            i_q            <= '0;
            j_q            <= '0;
            k_q            <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            c_q            <= c_d;
            i_q            <= i_d;
            j_q            <= j_d;
            k_q            <= k_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            illegal_q      <= illegal_d;
        end
    end

endmodule

// File: doc/matrix_exec_unit.md
Name: matrix_exec_unit

Overview:
- Execute-stage coprocessor for the custom matrix opcode (7'b1110111).
- Consumes the decoded matrix enables from the ID-stage control decoder, together with operand register values.
- Holds NxN matrices A and B and computes C = A*B with a single sequential MAC.
- Stalls the pipeline while busy and returns one result word for the register-writeback path (output select 2'b11).

Parameters:
- N, 2, matrix dimension; supported values 2..4.
- DATA_W, 32, element and result width, signed two's complement.
- IDX_W, 4, element index width; must satisfy 2^IDX_W >= N*N.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  a matrix instruction is present this cycle.
- load_a_en  input  1  LMA: write element of A.
- load_b_en  input  1  LMB: write element of B.
- matmul_en  input  1  MATMUL: compute C = A*B.
- inv_en  input  1  MATINV: unsupported in this block.
- rs1_data  input  DATA_W  element value for loads.
- rs2_data  input  DATA_W  element index, row-major, taken from bits [IDX_W-1:0].
- stall  output  1  hold IF/ID and ID/EX; instruction must not advance.
- result_valid  output  1  one-cycle pulse; result_data is valid.
- result_data  output  DATA_W  writeback value.
- illegal_op  output  1  one-cycle pulse on an unsupported, conflicting or out-of-range op.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; stall = 0, result_valid = 0, result_data = 0, illegal_op = 0.
  - A, B, C, counters and accumulator cleared to 0.
  - Reset mid-MATMUL aborts the operation with no result pulse.
- FSM states: IDLE, MAC, DONE.
- Accept rule: an op is accepted only when issue_valid = 1 and state = IDLE. issue_valid is ignored in MAC and DONE, because the stalled instruction is the one completing.
- Enable priority: matmul_en > load_a_en > load_b_en > inv_en.
  - More than one enable high: the highest priority op executes and illegal_op pulses for one cycle.
- LMA/LMB:
  - Single cycle; state stays IDLE; no stall.
  - Next cycle: A/B[idx] = rs1_data, result_valid = 1, result_data = rs1_data (echo).
  - idx >= N*N: no write, illegal_op = 1, result_valid = 1, result_data = 0.
- MATINV: next cycle result_valid = 1, result_data = 0, illegal_op = 1; no state change.
- MATMUL:
  - Issue cycle T: stall = 1 combinationally (issue_valid & matmul_en & IDLE). Capture idx from rs2_data and go to MAC.
  - MAC: counters i, j, k (k innermost), one product per cycle, acc += A[i][k]*B[k][j].
    - Accumulator width 2*DATA_W + clog2(N).
    - On k = N-1, write C[i][j] = low DATA_W bits of the final sum, then clear acc.
    - N^3 MAC cycles, T+1 .. T+N^3; stall = 1 throughout.
  - DONE at T+N^3+1: stall = 0, result_valid = 1, result_data = C[idx] (0 with illegal_op = 1 if idx >= N*N); next state IDLE.
  - Total stall N^3+1 cycles; for N = 2 the result arrives 9 cycles after issue.
- A and B are unchanged by MATMUL. C persists until the next MATMUL or reset.
- Loads issued back to back every cycle are all accepted.

Optional Feature:
- Macro: MATMUL_SATURATE_EN.
- Defined: each C element is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when the full-width sum overflows DATA_W.
- Undefined: each C element wraps, keeping the low DATA_W bits.
- Timing is identical in both builds.

Test Plan:
- Reset: assert reset mid-MATMUL, at cycle T+3 -> stall, result_valid and illegal_op = 0 immediately; no result pulse afterwards; a subsequent MATMUL on all-zero A, B returns 0.
- Loads and MATMUL:
  - Stimulus: N = 2, load A = [1,2;3,4] and B = [5,6;7,8] via 8 back-to-back loads; MATMUL with rs2_data = 3.
  - Response: each load echoes its value the next cycle; stall high for 9 cycles; result_valid at T+9 with result_data = 50.
  - Repeat with rs2_data = 0, 1, 2 -> 19, 22, 43.
- Out-of-range index: LMA with rs2_data = 7 (N = 2) -> illegal_op = 1, result_data = 0, A unchanged.
- Conflict: load_a_en and load_b_en high together with rs1_data = 9, idx 0 -> A[0] = 9, B[0] unchanged, illegal_op = 1.
- Overflow: A all 0x7FFFFFFF, B all 2, MATMUL idx 0 -> 0xFFFFFFFC without the macro; 0x7FFFFFFF with MATMUL_SATURATE_EN.
- MATINV and held issue: MATINV -> result 0 with illegal_op pulse. Holding issue_valid and matmul_en high through MAC -> exactly one result pulse, no restart.
